// File: rtl/det_result_collector.sv
// det_result_collector
//
// Sink for the 2x2 determinant datapath. Each accepted signed result is
// buffered in a small first-word-fall-through FIFO for a ready/valid
// consumer, and folded into running statistics: saturating sample count,
// wrapping signed sum, signed minimum and signed maximum.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high; clears FIFO, stats and drop_err
//   in_valid    producer offers in_data this cycle
//   in_data     signed result (DATA_W bits, two's complement)
//   in_ready    FIFO not full
//   out_valid   FIFO head is valid
//   out_data    FIFO head value (combinational read)
//   out_ready   consumer takes the head this cycle
//   fill        current FIFO occupancy
//   sample_cnt  accepted-result count, saturating at all ones
//   sum         signed running sum, wraps modulo 2^SUM_W
//   min_val     signed minimum of accepted results
//   max_val     signed maximum of accepted results
//   drop_err    sticky: a result was offered while the FIFO was full
//
// Optional build macro DET_STATS_CLEAR_EN adds input stats_clr, which
// zeroes the statistics and drop_err without touching the FIFO.

module det_result_collector #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int SUM_W  = 12,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [CNT_W-1:0]           sample_cnt,
    output logic [SUM_W-1:0]           sum,
    output logic [DATA_W-1:0]          min_val,
    output logic [DATA_W-1:0]          max_val,
`ifdef DET_STATS_CLEAR_EN
    input  logic                       stats_clr,
`endif
    output logic                       drop_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              drop_q, drop_d;

    logic              push, pop, seen, statsClr;
    logic [SUM_W-1:0]  dataExt;

`ifdef DET_STATS_CLEAR_EN
    assign statsClr = stats_clr;
`else
    assign statsClr = 1'b0;
`endif

    // Handshake decode. in_ready depends only on registered fill, so a full
    // FIFO refuses input even if the head is being popped in the same cycle.
    assign in_ready  = (fill_q != FILL_W'(DEPTH));
    assign out_valid = (fill_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_q[rdPtr_q];
    assign fill      = fill_q;

    // Size cast of a signed operand sign-extends into the accumulator width.
    assign dataExt = SUM_W'($signed(in_data));
    assign seen    = (cnt_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        fill_d  = fill_q;
        if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
        if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
        if (push && !pop)
            fill_d = fill_q + FILL_W'(1);
        else if (pop && !push)
            fill_d = fill_q - FILL_W'(1);
    end

    // Statistics. A push coinciding with a clear (or arriving when nothing
    // has been seen yet) restarts the stats from that single sample.
    // The count saturates, while sum/min/max keep tracking every push.
    always_comb begin
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        min_d  = min_q;
        max_d  = max_q;
        drop_d = drop_q;
        if (statsClr) begin
            cnt_d  = '0;
            sum_d  = '0;
            min_d  = '0;
            max_d  = '0;
            drop_d = 1'b0;
        end
        if (push) begin
            if (statsClr || !seen) begin
                cnt_d = CNT_W'(1);
                sum_d = dataExt;
                min_d = in_data;
                max_d = in_data;
            end else begin
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                sum_d = sum_q + dataExt;
                if ($signed(in_data) < $signed(min_q)) min_d = in_data;
                if ($signed(in_data) > $signed(max_q)) max_d = in_data;
            end
        end
        if (in_valid && !in_ready) drop_d = 1'b1;
    end

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= in_data;
    end

    // State registers; reset overrides any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            drop_q  <= drop_d;
        end
    end

    assign sample_cnt = cnt_q;
    assign sum        = sum_q;
    assign min_val    = min_q;
    assign max_val    = max_q;
    assign drop_err   = drop_q;

endmodule

// File: tb/tb_det_result_collector.sv
// tb_det_result_collector
//
// Bench for det_result_collector with default parameters. The driver issues
// one cycle of stimulus per call and keeps a reference model: the list of
// every result accepted since reset (stats are recomputed from that list)
// plus the FIFO occupancy. Each accepted result is also pushed into a
// scoreboard queue that an independent monitor drains whenever the DUT
// hands a result to the consumer.

module tb_det_result_collector;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int SUM_W  = 12;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [2:0]        fill;
    logic [CNT_W-1:0]  sample_cnt;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] min_val;
    logic [DATA_W-1:0] max_val;
    logic              drop_err;
`ifdef DET_STATS_CLEAR_EN
    logic              stats_clr = 1'b0;
`endif

    det_result_collector #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SUM_W(SUM_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .fill(fill), .sample_cnt(sample_cnt), .sum(sum),
        .min_val(min_val), .max_val(max_val),
`ifdef DET_STATS_CLEAR_EN
        .stats_clr(stats_clr),
`endif
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   mFill = 0;
    bit   mDrop = 1'b0;
    int   accepted[$];
    logic [DATA_W-1:0] sbQ[$];

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int modelSum();
        int s = 0;
        foreach (accepted[i]) s += accepted[i];
        return ((s % 4096) + 4096) % 4096;
    endfunction

    function automatic int modelMin();
        int m;
        if (accepted.size() == 0) return 0;
        m = accepted[0];
        foreach (accepted[i]) if (accepted[i] < m) m = accepted[i];
        return m & 255;
    endfunction

    function automatic int modelMax();
        int m;
        if (accepted.size() == 0) return 0;
        m = accepted[0];
        foreach (accepted[i]) if (accepted[i] > m) m = accepted[i];
        return m & 255;
    endfunction

    // One clock of stimulus: check the DUT state left by the previous edge
    // against the model, then advance the model for the coming edge.
    task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d,
                                 input bit r, input bit rst);
        bit doPush, doPop;
        @(negedge clk);
        reset     = rst;
        in_valid  = v;
        in_data   = d;
        out_ready = rst ? 1'b0 : r;
        #1;
        checkOutput("in_ready",   in_ready,   (mFill != DEPTH));
        checkOutput("out_valid",  out_valid,  (mFill != 0));
        checkOutput("fill",       fill,       mFill);
        checkOutput("sample_cnt", sample_cnt, (accepted.size() > 255) ? 255 : accepted.size());
        checkOutput("sum",        sum,        modelSum());
        checkOutput("min_val",    min_val,    modelMin());
        checkOutput("max_val",    max_val,    modelMax());
        checkOutput("drop_err",   drop_err,   mDrop);
        if (rst) begin
            mFill = 0;
            mDrop = 1'b0;
            accepted.delete();
            sbQ.delete();
        end else begin
            doPush = v && (mFill != DEPTH);
            doPop  = out_ready && (mFill != 0);
            if (v && mFill == DEPTH) mDrop = 1'b1;
            if (doPush) begin
                accepted.push_back(int'($signed(d)));
                sbQ.push_back(d);
            end
            mFill = mFill + int'(doPush) - int'(doPop);
        end
    endtask

    // Monitor: whenever the consumer takes the head, compare it with the
    // oldest result the driver saw accepted.
    initial begin
        logic [DATA_W-1:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (reset !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL out_data: got 0x%0h, expected nothing (scoreboard empty)", out_data);
                end else begin
                    exp = sbQ.pop_front();
                    checkOutput("out_data", out_data, exp);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Idle after reset
        applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);

        // Three pushes with the consumer stalled
        applyStimulus(1, 8'h05, 0, 0);
        applyStimulus(1, 8'hFE, 0, 0);
        applyStimulus(1, 8'h10, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("tp_fill",  fill,       3);
        checkOutput("tp_head",  out_data,   'h05);
        checkOutput("tp_sum",   sum,        'h013);
        checkOutput("tp_min",   min_val,    'hFE);
        checkOutput("tp_max",   max_val,    'h10);
        checkOutput("tp_cnt",   sample_cnt, 3);

        // Reset mid-stream with a push asserted
        applyStimulus(1, 8'h33, 1, 1);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("rst_fill", fill, 0);
        checkOutput("rst_sum",  sum,  0);

        // Overfill: fifth push is dropped
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h11 + i), 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("ovf_drop", drop_err,   1);
        checkOutput("ovf_fill", fill,       4);
        checkOutput("ovf_cnt",  sample_cnt, 4);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("ovf_empty", out_valid, 0);

        // Simultaneous push/pop at fill=2 across pointer wrap
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(1, 8'd1, 0, 0);
        applyStimulus(1, 8'd2, 0, 0);
        for (int i = 3; i < 20; i++) applyStimulus(1, 8'(i), 1, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("stream_fill", fill, 2);

        // Sum wrap: 40 x 0x7F
        applyStimulus(0, 8'h00, 0, 1);
        for (int i = 0; i < 40; i++) applyStimulus(1, 8'h7F, 1, 0);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("wrap_sum", sum,     'h3D8);
        checkOutput("wrap_min", min_val, 'h7F);
        checkOutput("wrap_max", max_val, 'h7F);

        // Counter saturation while sum/min/max keep moving
        applyStimulus(0, 8'h00, 0, 1);
        for (int i = 0; i < 260; i++) applyStimulus(1, 8'($urandom), 1, 0);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("sat_cnt", sample_cnt, 255);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++)
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);

        // Drain
        for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 1, 0);
        checkOutput("drain_sb", sbQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
